// File: rtl/enum_index_sched.sv
// enum_index_sched: a 4-entry lookup table shared by NUM_REQ requesters through
// a round-robin arbiter.
//
// The granted requester's 2-bit selector becomes a 3-bit index, sel + 1.
// Indices 1..3 read that entry. Index 4 reads entry 3 and sets out_oob.
// The registered result sits in a one-deep output slot with a valid/ready
// handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_en      table write strobe
//   wr_addr    entry to write
//   wr_data    write data
//   req_valid  per-requester lookup request
//   req_sel    per-requester selector, requester i on bits [2i+1:2i]
//   req_ready  per-requester grant (one-hot or zero, combinational)
//   out_valid  result valid
//   out_data   looked-up entry
//   out_id     requester that owns out_data
//   out_oob    the index was clamped to entry 3
//   out_ready  downstream accepts the result
module enum_index_sched #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [1:0]           wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [1:0]           out_id,
  output logic                 out_oob,
  input  logic                 out_ready
);

  localparam logic [1:0] LastGrantInit = 2'(NUM_REQ - 1);

  logic [DATA_W-1:0] tbl_q [4];
  logic [1:0]        last_grant_q;

  logic              slot_free;
  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic              grant;
  logic [1:0]        win_sel;
  logic [2:0]        lookup_idx;
  logic              lookup_oob;
  logic [1:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign slot_free = !out_valid || out_ready;

  // Round-robin search from last_grant + 1. The first pass covers requesters
  // above last_grant. The second pass wraps to requester 0 through last_grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req_valid[i] && (2'(i) > last_grant_q)) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req_valid[i] && (2'(i) <= last_grant_q)) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(i);
      end
    end
  end

  assign grant = gnt_any && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    win_sel   = 2'd0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        req_ready[i] = grant;
        win_sel      = req_sel[2*i +: 2];
      end
    end
  end

  // The index is kept at 3 bits so that sel = 3 reaches 4 and can be clamped.
  // The table read happens before this cycle's write lands, so a lookup that
  // collides with a write returns the old value.
  assign lookup_idx = {1'b0, win_sel} + 3'd1;
  assign lookup_oob = lookup_idx[2];
  assign rd_addr    = lookup_oob ? 2'd3 : lookup_idx[1:0];
  assign rd_data    = tbl_q[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        tbl_q[i] <= '0;
      end
      last_grant_q <= LastGrantInit;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_id       <= 2'd0;
      out_oob      <= 1'b0;
    end else begin
      if (wr_en) begin
        tbl_q[wr_addr] <= wr_data;
      end
      if (grant) begin
        last_grant_q <= gnt_idx;
        out_valid    <= 1'b1;
        out_data     <= rd_data;
        out_id       <= gnt_idx;
        out_oob      <= lookup_oob;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enum_index_sched.sv
// Bench for enum_index_sched.
// The driver applies directed vectors and pushes hand-computed results into a
// scoreboard queue. A monitor pops and compares on every accepted output.
module tb_enum_index_sched;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DATA_W  = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [1:0]           wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_sel;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [1:0]           out_id;
  logic                 out_oob;
  logic                 out_ready;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {oob, id, data}
  logic [DATA_W+2:0] sb [$];

  always #5 clk = ~clk;

  enum_index_sched #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_oob  (out_oob),
    .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [1:0] id, input logic oob);
    sb.push_back({oob, id, d});
  endtask

  // Monitor: one pop per accepted result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=0x%0h id=%0d oob=%0d, expected nothing",
                 out_data, out_id, out_oob);
      end else begin
        logic [DATA_W+2:0] e;
        e = sb.pop_front();
        if ({out_oob, out_id, out_data} !== e) begin
          errors++;
          $display("FAIL sb_result: got data=0x%0h id=%0d oob=%0d, expected data=0x%0h id=%0d oob=%0d",
                   out_data, out_id, out_oob, e[DATA_W-1:0], e[DATA_W+1:DATA_W], e[DATA_W+2]);
        end
      end
    end
  end

  initial begin
    // Reset with requests pending and an attempted write to entry 1.
    rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h55;
    req_valid = 3'b111; req_sel = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(3'b000));
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", 64'({out_oob, out_id, out_data}), 64'd0);
    tick();
    rst = 1'b0; wr_en = 1'b0; req_valid = '0;

    // Entry 1 must still be zero.
    req_valid = 3'b001; req_sel = 6'b00_00_00;
    push(32'h0, 2'd0, 1'b0);
    @(negedge clk); chk("first_grant_req0", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;

    // Fill the table with 0x10..0x13.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 32'h10 + 32'(i);
      tick();
    end
    wr_en = 1'b0;

    req_valid = 3'b001; req_sel = 6'b00_00_00;
    push(32'h11, 2'd0, 1'b0);
    @(negedge clk); chk("req0_sel0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b010; req_sel = 6'b00_11_00;
    push(32'h13, 2'd1, 1'b1);
    @(negedge clk); chk("req1_sel3_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_sel = 6'b00_10_00;
    push(32'h13, 2'd1, 1'b0);
    @(negedge clk); chk("req1_sel2_ready", 64'(req_ready), 64'(3'b010));
    tick();
    // A lone request from requester 2 moves last_grant to 2.
    req_valid = 3'b100; req_sel = 6'b00_00_00;
    push(32'h11, 2'd2, 1'b0);
    @(negedge clk); chk("req2_ready", 64'(req_ready), 64'(3'b100));
    tick();

    // Everyone requesting: grants rotate 0,1,2,0,1,2.
    req_valid = 3'b111; req_sel = 6'b10_01_00;
    for (int i = 0; i < 6; i++) begin
      push(32'h11 + 32'(i % 3), 2'(i % 3), 1'b0);
      @(negedge clk); chk($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(1 << (i % 3)));
      tick();
    end

    // Grant requester 0, then stall for three cycles.
    push(32'h11, 2'd0, 1'b0);
    @(negedge clk); chk("pre_stall_ready", 64'(req_ready), 64'(3'b001));
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_ready_%0d", i), 64'(req_ready), 64'(3'b000));
      chk($sformatf("stall_hold_%0d", i), 64'({out_valid, out_oob, out_id, out_data}),
          64'({1'b1, 1'b0, 2'd0, 32'h11}));
      tick();
    end
    out_ready = 1'b1;
    push(32'h12, 2'd1, 1'b0);
    @(negedge clk); chk("unstall_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;

    // A lookup that collides with a write returns the old entry, then the new one.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hAA;
    req_valid = 3'b001; req_sel = 6'b00_00_01;
    push(32'h12, 2'd0, 1'b0);
    @(negedge clk); chk("bypass_ready", 64'(req_ready), 64'(3'b001));
    tick();
    push(32'hAA, 2'd0, 1'b0);
    tick();
    wr_en = 1'b0;

    // Reset while a result is held.
    req_valid = 3'b111; out_ready = 1'b0; req_sel = 6'b10_10_10;
    @(negedge clk); chk("held_ready", 64'(req_ready), 64'(3'b000));
    tick();
    rst = 1'b1;
    sb.delete();
    @(negedge clk); chk("rst_hold_ready", 64'(req_ready), 64'(3'b000));
    tick();
    rst = 1'b0; out_ready = 1'b1;
    push(32'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
